// File: rtl/spi_pkg.sv
// Shared constants and types for the write-only SPI register target.
// Frame layout, register address map and FSM state encoding.
package spi_pkg;

   localparam int FRAME_BITS = 16;

   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY      = 7'h04;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus an edge register.
// Ports: clk_i, rst_n_i, d_i (raw pin); level_o, rise_o, fall_o (clk domain).
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = level_o & ~prev_q;
   assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 write-only SPI target driving the five PWM control registers.
// Ports: clk, rst_n, sclk/copi/ncs pins in; five 8-bit register outputs.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_REGS    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic copi_lvl, copi_rise, copi_fall;
   logic ncs_lvl, ncs_rise, ncs_fall;

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (1'b0)
   ) u_sclk (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .d_i     (sclk),
      .level_o (sclk_lvl),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (1'b0)
   ) u_copi (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .d_i     (copi),
      .level_o (copi_lvl),
      .rise_o  (copi_rise),
      .fall_o  (copi_fall)
   );

   // Idle-high reset value keeps reset release from looking like a frame start.
   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (1'b1)
   ) u_ncs (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .d_i     (ncs),
      .level_o (ncs_lvl),
      .rise_o  (ncs_rise),
      .fall_o  (ncs_fall)
   );

   logic unused_edges;
   assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

   state_e      state_q;
   logic [15:0] shift_q, shift_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        ovf_q;
   logic        relatch_q;
   logic [7:0]  reg0_q, reg1_q, reg2_q, reg3_q, reg4_q;
   logic        frame_ok;

   assign shift_d = {shift_q[14:0], copi_lvl};
   assign cnt_d   = cnt_q + 5'd1;

   assign frame_ok = (cnt_q == 5'(FRAME_BITS)) && !ovf_q &&
                     shift_q[15] &&
                     (shift_q[14:8] < 7'(NUM_REGS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         relatch_q <= 1'b0;
         reg0_q    <= '0;
         reg1_q    <= '0;
         reg2_q    <= '0;
         reg3_q    <= '0;
         reg4_q    <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               relatch_q <= 1'b0;
               // relatch_q catches a falling edge that landed during COMMIT.
               if (ncs_fall || (!ncs_lvl && relatch_q)) begin
                  state_q <= ST_SHIFT;
                  shift_q <= '0;
                  cnt_q   <= '0;
                  ovf_q   <= 1'b0;
               end
            end
            ST_SHIFT: begin
               // ncs rise wins over a coincident sclk rise.
               if (ncs_rise) begin
                  state_q <= frame_ok ? ST_COMMIT : ST_IDLE;
               end else if (sclk_rise && !ncs_lvl) begin
                  if (cnt_q == 5'(FRAME_BITS)) begin
                     ovf_q <= 1'b1;
                  end else begin
                     shift_q <= shift_d;
                     cnt_q   <= cnt_d;
                  end
               end
            end
            ST_COMMIT: begin
               case (shift_q[14:8])
                  ADDR_EN_OUT_LO: reg0_q <= shift_q[7:0];
                  ADDR_EN_OUT_HI: reg1_q <= shift_q[7:0];
                  ADDR_EN_PWM_LO: reg2_q <= shift_q[7:0];
                  ADDR_EN_PWM_HI: reg3_q <= shift_q[7:0];
                  ADDR_DUTY:      reg4_q <= shift_q[7:0];
                  default: ;
               endcase
               relatch_q <= !ncs_lvl;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign en_reg_out_7_0  = reg0_q;
   assign en_reg_out_15_8 = reg1_q;
   assign en_reg_pwm_7_0  = reg2_q;
   assign en_reg_pwm_15_8 = reg3_q;
   assign pwm_duty_cycle  = reg4_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: frames update a register-map model,
// and a monitor compares all five outputs after each nCS rising edge.
module tb_spi_peripheral;

   localparam int HALF = 5;
   localparam int LAT  = 5;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk  = 1'b0;
   logic       copi  = 1'b0;
   logic       ncs   = 1'b1;
   logic [7:0] o0, o1, o2, o3, o4;

   spi_peripheral #(
      .SYNC_STAGES (2),
      .NUM_REGS    (5)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .en_reg_out_7_0  (o0),
      .en_reg_out_15_8 (o1),
      .en_reg_pwm_7_0  (o2),
      .en_reg_pwm_15_8 (o3),
      .pwm_duty_cycle  (o4)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  model [5];
   logic [39:0] exp_q [$];
   string       tag_q [$];
   logic [39:0] e;
   string       t;

   function automatic logic [39:0] snap();
      return {model[4], model[3], model[2], model[1], model[0]};
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Only a complete 16-bit write to an implemented address lands.
   task automatic model_frame(logic [31:0] b, int n);
      int a;
      a = int'(b[14:8]);
      if (n == 16 && b[15] && a < 5) model[a] = b[7:0];
   endtask

   task automatic shift_bits(logic [31:0] b, int n);
      for (int i = n - 1; i >= 0; i--) begin
         copi = b[i];
         tick(HALF);
         sclk = 1'b1;
         tick(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic end_frame(string tag, int gap);
      tick(HALF);
      exp_q.push_back(snap());
      tag_q.push_back(tag);
      ncs = 1'b1;
      tick(gap);
   endtask

   task automatic frame(string tag, logic [31:0] b, int n, int gap);
      model_frame(b, n);
      ncs = 1'b0;
      tick(HALF);
      shift_bits(b, n);
      end_frame(tag, gap);
   endtask

   initial begin
      forever begin
         @(posedge ncs);
         repeat (LAT) @(posedge clk);
         @(negedge clk);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got nCS rise expected none");
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".out_lo"}, o0, e[7:0]);
            chk({t, ".out_hi"}, o1, e[15:8]);
            chk({t, ".pwm_lo"}, o2, e[23:16]);
            chk({t, ".pwm_hi"}, o3, e[31:24]);
            chk({t, ".duty"},   o4, e[39:32]);
         end
      end
   end

   initial begin
      logic [31:0] b;
      int          n;
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      tick(5);
      rst_n = 1'b1;
      tick(50);
      frame("reset_probe", 32'h0, 0, 4);

      frame("w_81A5", 32'h81A5, 16, 4);
      frame("w_8480", 32'h8480, 16, 4);
      frame("rd_04FF", 32'h04FF, 16, 4);
      frame("bad_addr_853C", 32'h853C, 16, 4);
      frame("short12", 32'h08F1, 12, 4);
      frame("long17", {15'h0, 16'h82F0, 1'b1}, 17, 4);
      frame("w_82F0", 32'h82F0, 16, 4);
      frame("b2b_8011", 32'h8011, 16, 2);
      frame("b2b_8322", 32'h8322, 16, 4);

      ncs = 1'b0;
      tick(HALF);
      shift_bits(32'h83, 8);
      rst_n = 1'b0;
      tick(3);
      chk("rst_mid.out_lo", o0, 8'h00);
      chk("rst_mid.out_hi", o1, 8'h00);
      chk("rst_mid.pwm_lo", o2, 8'h00);
      chk("rst_mid.pwm_hi", o3, 8'h00);
      chk("rst_mid.duty",   o4, 8'h00);
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      rst_n = 1'b1;
      tick(2);
      shift_bits(32'hFF, 8);
      end_frame("rst_abort", 4);
      frame("w_83FF", 32'h83FF, 16, 4);

      for (int k = 0; k < 24; k++) begin
         b = {16'h0, ($urandom_range(0, 4) != 0),
              7'($urandom_range(0, 7)), 8'($urandom)};
         case ($urandom_range(0, 9))
            0: n = 15;
            1: begin n = 17; b = {b[30:0], 1'($urandom)}; end
            default: n = 16;
         endcase
         frame($sformatf("rnd%0d", k), b, n, $urandom_range(1, 6));
      end

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      tick(LAT + 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
